// File: rtl/cylon_sequencer_if.sv
// Control/status bundle between board-side logic and the cylon playlist sequencer.
// step_req exists only when CYLON_SEQ_MANUAL_STEP_EN is defined.
interface cylon_sequencer_if;
    logic       enable;
    logic       hold;
`ifdef CYLON_SEQ_MANUAL_STEP_EN
    logic       step_req;
`endif
    logic [1:0] mode;
    logic [3:0] speed;
    logic [3:0] step_index;
    logic       step_strobe;

`ifdef CYLON_SEQ_MANUAL_STEP_EN
    modport master (output enable, hold, step_req, input mode, speed, step_index, step_strobe);
    modport slave  (input enable, hold, step_req, output mode, speed, step_index, step_strobe);
`else
    modport master (output enable, hold, input mode, speed, step_index, step_strobe);
    modport slave  (input enable, hold, output mode, speed, step_index, step_strobe);
`endif
endinterface

// File: rtl/cylon_sequencer.sv
// Playlist scheduler driving the cylon engine's mode/speed from a table of timed steps.
// Optional manual-advance button: define CYLON_SEQ_MANUAL_STEP_EN.
module cylon_sequencer #(
    parameter int                      CLKS_PER_TICK = 25_000_000,
    parameter int                      NUM_STEPS     = 4,
    parameter logic [NUM_STEPS*14-1:0] PLAYLIST      = {14'h0410, 14'h2208, 14'h1208, 14'h0008}
) (
    input  logic              clk,
    input  logic              rst_n,
    cylon_sequencer_if.slave  bus
);
    localparam int            PW       = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [PW-1:0] PS_LAST  = PW'(CLKS_PER_TICK - 1);
    localparam logic [3:0]    IDX_LAST = 4'(NUM_STEPS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t        state, state_nxt;
    logic [3:0]    idx, idx_nxt;
    logic [PW-1:0] presc;
    logic [7:0]    remain;
    logic [13:0]   entry;
    logic          tick, advance, manual_edge;

`ifdef CYLON_SEQ_MANUAL_STEP_EN
    // Two flops to synchronise the button, third flop for rising-edge detect.
    logic [2:0] req_sync;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_sync <= '0;
        else        req_sync <= {req_sync[1:0], bus.step_req};
    end
    assign manual_edge = req_sync[1] & ~req_sync[2];
`else
    assign manual_edge = 1'b0;
`endif

    assign entry = PLAYLIST[int'(idx)*14 +: 14];

    always_comb begin
        tick      = (state == RUN) && !bus.hold && (presc == PS_LAST);
        advance   = (state == RUN) && ((tick && remain == 8'd1) || manual_edge);
        state_nxt = state;
        idx_nxt   = idx;
        if (!bus.enable) begin
            state_nxt = IDLE;
            idx_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = LOAD;
                    idx_nxt   = '0;
                end
                LOAD: state_nxt = RUN;
                RUN: if (advance) begin
                    state_nxt = LOAD;
                    idx_nxt   = (idx == IDX_LAST) ? 4'd0 : idx + 4'd1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Outputs only update on LOAD exit so the engine never sees a half-applied step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.mode        <= '0;
            bus.speed       <= '0;
            bus.step_index  <= '0;
            bus.step_strobe <= 1'b0;
            presc           <= '0;
            remain          <= '0;
        end else begin
            bus.step_strobe <= 1'b0;
            if (!bus.enable || state == IDLE) begin
                bus.mode       <= '0;
                bus.speed      <= '0;
                bus.step_index <= '0;
                presc          <= '0;
                remain         <= '0;
            end else if (state == LOAD) begin
                bus.mode        <= entry[13:12];
                bus.speed       <= entry[11:8];
                bus.step_index  <= idx;
                bus.step_strobe <= 1'b1;
                remain          <= (entry[7:0] == 8'd0) ? 8'd1 : entry[7:0];
                presc           <= '0;
            end else if (!bus.hold) begin
                if (tick) begin
                    presc  <= '0;
                    remain <= remain - 8'd1;
                end else begin
                    presc  <= presc + PW'(1);
                end
            end
        end
    end
endmodule
